// File: rtl/memory_read_scheduler_if.sv
// Bundle between the read scheduler, its requesters and the instruction-memory read port.
// Every request channel (req_*, mem_*) transfers on a cycle where valid & ready are both high;
// a valid request keeps its address stable until that handshake, and ready may depend on valid.
interface memory_read_scheduler_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  localparam int ID_BITS = $clog2(N);

  logic [N-1:0]        req_valid;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ready;
  logic [DATA_W-1:0]   mem_data;
  logic                busy;
  logic [ID_BITS-1:0]  dbg_ptr;

  modport slave (
    input  req_valid, req_addr, mem_ready, mem_data,
    output req_ready, rsp_valid, rsp_data, mem_valid, mem_addr, busy, dbg_ptr
  );

  modport master (
    output req_valid, req_addr, mem_ready, mem_data,
    input  req_ready, rsp_valid, rsp_data, mem_valid, mem_addr, busy, dbg_ptr
  );
endinterface

// File: rtl/memory_read_scheduler.sv
// Round-robin sharing of one instruction-memory read port among N requesters, with a registered
// request stage and an owner-tag pipe that routes each returning word to the requester that issued it.
module memory_read_scheduler #(
  parameter int N                 = 4,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_WIDTH      = 16,
  parameter int READ_LATENCY      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_read_scheduler_if.slave bus
);
  localparam int ID_BITS = $clog2(N);
  localparam int AW      = MEMORY_ADDR_WIDTH;

  logic                                 stage_valid_q, stage_valid_d;
  logic [AW-1:0]                        stage_addr_q, stage_addr_d;
  logic [ID_BITS-1:0]                   stage_owner_q, stage_owner_d;
  logic [ID_BITS-1:0]                   ptr_q, ptr_d;
  logic [READ_LATENCY-1:0]              pipe_valid_q, pipe_valid_d;
  logic [READ_LATENCY-1:0][ID_BITS-1:0] pipe_owner_q, pipe_owner_d;

  logic               can_load;
  logic               found;
  logic               accept;
  logic [ID_BITS-1:0] winner;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  int                 arb_idx;

  assign can_load = ~stage_valid_q | bus.mem_ready;

  // Search starts at ptr and wraps modulo N, so the requester after the last winner has priority.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    arb_idx = 0;
    for (int k = 0; k < N; k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= N) arb_idx = arb_idx - N;
      if (!found && bus.req_valid[arb_idx]) begin
        found  = 1'b1;
        winner = ID_BITS'(arb_idx);
      end
    end
  end

  // Grants are suppressed while reset is held, even though the stage already reads empty.
  assign accept = found & can_load & rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    stage_owner_d = stage_owner_q;
    ptr_d         = ptr_q;
    if (accept) begin
      stage_valid_d = 1'b1;
      stage_addr_d  = bus.req_addr[int'(winner)*AW +: AW];
      stage_owner_d = winner;
      ptr_d         = (int'(winner) == N - 1) ? '0 : winner + 1'b1;
    end else if (stage_valid_q && bus.mem_ready) begin
      stage_valid_d = 1'b0;
    end
  end

  // The pipe never stalls: memory returns data a fixed time after the handshake regardless.
  always_comb begin
    pipe_valid_d    = '0;
    pipe_owner_d    = '0;
    pipe_valid_d[0] = stage_valid_q & bus.mem_ready;
    pipe_owner_d[0] = stage_owner_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_owner_d[i] = pipe_owner_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_owner_q <= '0;
      ptr_q         <= '0;
      pipe_valid_q  <= '0;
      pipe_owner_q  <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_owner_q <= stage_owner_d;
      ptr_q         <= ptr_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_owner_q  <= pipe_owner_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pipe_valid_q[READ_LATENCY-1]) rsp_valid[pipe_owner_q[READ_LATENCY-1]] = 1'b1;
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = bus.mem_data;
  assign bus.mem_valid = stage_valid_q;
  assign bus.mem_addr  = stage_addr_q;
  assign bus.busy      = stage_valid_q | (|pipe_valid_q);
  assign bus.dbg_ptr   = ptr_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst) $onehot0(rsp_valid));
  a_stage_hold:   assert property (@(posedge clk) disable iff (!rst)
                    (stage_valid_q && !bus.mem_ready) |=> (stage_valid_q && $stable(stage_addr_q)));
endmodule

// File: tb/tb_memory_read_scheduler.sv
// Bench for memory_read_scheduler: a 4-requester instance with two-cycle memory latency and a
// 2-requester instance with one-cycle latency, each fed by a small memory model.
module tb_memory_read_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_read_scheduler_if #(.N(4), .ADDR_W(11), .DATA_W(16)) if_a ();
  memory_read_scheduler_if #(.N(2), .ADDR_W(11), .DATA_W(16)) if_b ();

  memory_read_scheduler #(.N(4), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(16), .READ_LATENCY(2))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  memory_read_scheduler #(.N(2), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(16), .READ_LATENCY(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int compared   = 0;
  int mismatched = 0;
  logic [19:0] exp_q[$];
  logic [17:0] exp_b_q[$];
  int   hs_b      = 0;
  int   pulses_b  = 0;
  logic hs_prev_b = 1'b0;

  function automatic logic [15:0] mem_fn(input logic [10:0] a);
    return (a == 11'h005) ? 16'hBEEF : {a[7:0], ~a[7:0]};
  endfunction

  // Memory models: data appears READ_LATENCY cycles after the handshake.
  logic [15:0] mem_pipe_a [2];
  logic [15:0] mem_pipe_b;
  always @(posedge clk) begin
    mem_pipe_a[0] <= (if_a.mem_valid && if_a.mem_ready) ? mem_fn(if_a.mem_addr) : 16'hDEAD;
    mem_pipe_a[1] <= mem_pipe_a[0];
    mem_pipe_b    <= (if_b.mem_valid && if_b.mem_ready) ? mem_fn(if_b.mem_addr) : 16'hDEAD;
  end
  assign if_a.mem_data = mem_pipe_a[1];
  assign if_b.mem_data = mem_pipe_b;

  always @(posedge clk) begin
    hs_prev_b = rst && if_b.mem_valid && if_b.mem_ready;
    if (hs_prev_b) hs_b++;
  end

  always @(negedge clk) begin
    if (rst && if_a.rsp_valid !== 4'b0000) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL rsp_a_unexpected got rsp_valid=%b data=%h, none outstanding", if_a.rsp_valid, if_a.rsp_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({if_a.rsp_valid, if_a.rsp_data} !== e) begin
          mismatched++;
          $display("FAIL rsp_a_scoreboard got %b/%h expected %b/%h", if_a.rsp_valid, if_a.rsp_data, e[19:16], e[15:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      compared++;
      if ((if_b.rsp_valid != 2'b00) !== hs_prev_b) begin
        mismatched++;
        $display("FAIL rsp_b_timing got rsp_valid=%b expected pulse=%b", if_b.rsp_valid, hs_prev_b);
      end
      if (if_b.rsp_valid != 2'b00) begin
        pulses_b++;
        compared++;
        if (exp_b_q.size() == 0) begin
          mismatched++;
          $display("FAIL rsp_b_unexpected got rsp_valid=%b, none outstanding", if_b.rsp_valid);
        end else begin
          logic [17:0] e;
          e = exp_b_q.pop_front();
          if ({if_b.rsp_valid, if_b.rsp_data} !== e) begin
            mismatched++;
            $display("FAIL rsp_b_scoreboard got %b/%h expected %b/%h", if_b.rsp_valid, if_b.rsp_data, e[17:16], e[15:0]);
          end
        end
      end
    end
  end

  task automatic test_reset();
    if_a.req_valid = 4'hF; if_a.req_addr = '1; if_a.mem_ready = 1'b1;
    if_b.req_valid = 2'b11; if_b.req_addr = '1; if_b.mem_ready = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    compared++; if (if_a.req_ready !== 4'b0) begin mismatched++; $display("FAIL reset_req_ready got %b expected 0000", if_a.req_ready); end
    compared++; if (if_a.mem_valid !== 1'b0) begin mismatched++; $display("FAIL reset_mem_valid got %b expected 0", if_a.mem_valid); end
    compared++; if (if_a.mem_addr !== 11'h0) begin mismatched++; $display("FAIL reset_mem_addr got %h expected 000", if_a.mem_addr); end
    compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b expected 0", if_a.busy); end
    compared++; if (if_a.rsp_valid !== 4'b0) begin mismatched++; $display("FAIL reset_rsp_valid got %b expected 0000", if_a.rsp_valid); end
    compared++; if (if_a.dbg_ptr !== 2'd0) begin mismatched++; $display("FAIL reset_ptr got %0d expected 0", if_a.dbg_ptr); end
    compared++; if (if_b.req_ready !== 2'b0) begin mismatched++; $display("FAIL reset_b_req_ready got %b expected 00", if_b.req_ready); end
    compared++; if (if_b.busy !== 1'b0) begin mismatched++; $display("FAIL reset_b_busy got %b expected 0", if_b.busy); end
    if_a.req_valid = '0; if_b.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    if_a.req_addr = '0; if_a.req_addr[22 +: 11] = 11'h005; if_a.req_valid = 4'b0100; if_a.mem_ready = 1'b1;
    #1;
    compared++; if (if_a.req_ready !== 4'b0100) begin mismatched++; $display("FAIL single_grant got %b expected 0100", if_a.req_ready); end
    exp_q.push_back({4'b0100, 16'hBEEF});
    @(posedge clk); #1;
    if_a.req_valid = '0;
    compared++; if (if_a.mem_valid !== 1'b1) begin mismatched++; $display("FAIL single_mem_valid got %b expected 1", if_a.mem_valid); end
    compared++; if (if_a.mem_addr !== 11'h005) begin mismatched++; $display("FAIL single_mem_addr got %h expected 005", if_a.mem_addr); end
    compared++; if (if_a.busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_c1 got %b expected 1", if_a.busy); end
    compared++; if (if_a.dbg_ptr !== 2'd3) begin mismatched++; $display("FAIL single_ptr got %0d expected 3", if_a.dbg_ptr); end
    @(posedge clk); #1;
    compared++; if (if_a.busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_c2 got %b expected 1", if_a.busy); end
    compared++; if (if_a.mem_valid !== 1'b0) begin mismatched++; $display("FAIL single_drain got %b expected 0", if_a.mem_valid); end
    @(posedge clk); #1;
    compared++; if (if_a.rsp_valid !== 4'b0100) begin mismatched++; $display("FAIL single_rsp_valid got %b expected 0100", if_a.rsp_valid); end
    compared++; if (if_a.rsp_data !== 16'hBEEF) begin mismatched++; $display("FAIL single_rsp_data got %h expected beef", if_a.rsp_data); end
    @(posedge clk); #1;
    compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_c4 got %b expected 0", if_a.busy); end
    compared++; if (if_a.rsp_valid !== 4'b0) begin mismatched++; $display("FAIL single_rsp_done got %b expected 0000", if_a.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [10:0] rr_addr [4];
    logic [3:0]  oh;
    rst = 1'b0; exp_q.delete(); #1; rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rr_addr[i] = 11'($urandom_range(16, 2047));
      if_a.req_addr[i*11 +: 11] = rr_addr[i];
    end
    for (int k = 0; k < 10; k++) begin
      if_a.req_valid = (k < 6) ? 4'hF : 4'h0;
      #1;
      if (k < 6) begin
        oh = 4'b0001 << (k % 4);
        compared++; if (if_a.dbg_ptr !== 2'(k % 4)) begin mismatched++; $display("FAIL rr_ptr k=%0d got %0d expected %0d", k, if_a.dbg_ptr, k % 4); end
        compared++; if (if_a.req_ready !== oh) begin mismatched++; $display("FAIL rr_grant k=%0d got %b expected %b", k, if_a.req_ready, oh); end
        exp_q.push_back({oh, mem_fn(rr_addr[k % 4])});
      end else begin
        compared++; if (if_a.req_ready !== 4'b0) begin mismatched++; $display("FAIL rr_idle k=%0d got %b expected 0000", k, if_a.req_ready); end
      end
      if (k >= 3 && k < 9) begin
        oh = 4'b0001 << ((k - 3) % 4);
        compared++; if (if_a.rsp_valid !== oh) begin mismatched++; $display("FAIL rr_rsp k=%0d got %b expected %b", k, if_a.rsp_valid, oh); end
      end
      @(posedge clk); #1;
    end
    for (int w = 0; w < 20 && if_a.busy; w++) begin @(posedge clk); #1; end
    compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("FAIL rr_drain got busy=%b expected 0", if_a.busy); end
  endtask

  task automatic test_stall();
    if_a.mem_ready = 1'b0; if_a.req_addr = '0; if_a.req_addr[22 +: 11] = 11'h011; if_a.req_valid = 4'b0100;
    #1;
    compared++; if (if_a.req_ready !== 4'b0100) begin mismatched++; $display("FAIL stall_load got %b expected 0100", if_a.req_ready); end
    exp_q.push_back({4'b0100, mem_fn(11'h011)});
    @(posedge clk); #1;
    if_a.req_addr = '0; if_a.req_addr[0 +: 11] = 11'h020; if_a.req_addr[11 +: 11] = 11'h021; if_a.req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      compared++; if (if_a.mem_valid !== 1'b1 || if_a.mem_addr !== 11'h011) begin mismatched++; $display("FAIL stall_hold c=%0d got %b/%h expected 1/011", c, if_a.mem_valid, if_a.mem_addr); end
      compared++; if (if_a.req_ready !== 4'b0) begin mismatched++; $display("FAIL stall_ready c=%0d got %b expected 0000", c, if_a.req_ready); end
      compared++; if (if_a.dbg_ptr !== 2'd3) begin mismatched++; $display("FAIL stall_ptr c=%0d got %0d expected 3", c, if_a.dbg_ptr); end
      @(posedge clk); #1;
    end
    if_a.mem_ready = 1'b1;
    #1;
    compared++; if (if_a.req_ready !== 4'b0001) begin mismatched++; $display("FAIL stall_release_grant got %b expected 0001", if_a.req_ready); end
    compared++; if (if_a.mem_addr !== 11'h011) begin mismatched++; $display("FAIL stall_release_addr got %h expected 011", if_a.mem_addr); end
    exp_q.push_back({4'b0001, mem_fn(11'h020)});
    @(posedge clk); #2;
    compared++; if (if_a.req_ready !== 4'b0010) begin mismatched++; $display("FAIL stall_b2b_grant got %b expected 0010", if_a.req_ready); end
    compared++; if (if_a.mem_valid !== 1'b1 || if_a.mem_addr !== 11'h020) begin mismatched++; $display("FAIL stall_b2b_addr got %b/%h expected 1/020", if_a.mem_valid, if_a.mem_addr); end
    exp_q.push_back({4'b0010, mem_fn(11'h021)});
    @(posedge clk); #1;
    if_a.req_valid = '0;
    compared++; if (if_a.mem_valid !== 1'b1 || if_a.mem_addr !== 11'h021) begin mismatched++; $display("FAIL stall_b2b_addr2 got %b/%h expected 1/021", if_a.mem_valid, if_a.mem_addr); end
    for (int w = 0; w < 20 && if_a.busy; w++) begin @(posedge clk); #1; end
    compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("FAIL stall_drain got busy=%b expected 0", if_a.busy); end
  endtask

  task automatic test_ptr_wrap();
    compared++; if (if_a.dbg_ptr !== 2'd2) begin mismatched++; $display("FAIL wrap_start_ptr got %0d expected 2", if_a.dbg_ptr); end
    if_a.req_addr = '0; if_a.req_addr[33 +: 11] = 11'h033; if_a.req_addr[0 +: 11] = 11'h030; if_a.req_valid = 4'b1001;
    #1;
    compared++; if (if_a.req_ready !== 4'b1000) begin mismatched++; $display("FAIL wrap_first got %b expected 1000", if_a.req_ready); end
    exp_q.push_back({4'b1000, mem_fn(11'h033)});
    @(posedge clk); #1;
    if_a.req_valid = 4'b0001;
    #1;
    compared++; if (if_a.req_ready !== 4'b0001) begin mismatched++; $display("FAIL wrap_second got %b expected 0001", if_a.req_ready); end
    exp_q.push_back({4'b0001, mem_fn(11'h030)});
    @(posedge clk); #1;
    if_a.req_valid = '0;
    compared++; if (if_a.dbg_ptr !== 2'd1) begin mismatched++; $display("FAIL wrap_end_ptr got %0d expected 1", if_a.dbg_ptr); end
    for (int w = 0; w < 20 && if_a.busy; w++) begin @(posedge clk); #1; end
    compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("FAIL wrap_drain got busy=%b expected 0", if_a.busy); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] a;
    logic [3:0]  oh;
    if_a.req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      a = 11'($urandom_range(16, 2047));
      for (int i = 0; i < 4; i++) if_a.req_addr[i*11 +: 11] = a;
      #1;
      oh = 4'b0001 << (c + 1);
      compared++; if (if_a.req_ready !== oh) begin mismatched++; $display("FAIL rmid_grant c=%0d got %b expected %b", c, if_a.req_ready, oh); end
      exp_q.push_back({oh, mem_fn(a)});
      @(posedge clk); #1;
    end
    compared++; if (if_a.mem_valid !== 1'b1 || if_a.busy !== 1'b1) begin mismatched++; $display("FAIL rmid_setup got %b/%b expected 1/1", if_a.mem_valid, if_a.busy); end
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    compared++; if (if_a.mem_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_mem_valid got %b expected 0", if_a.mem_valid); end
    compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("FAIL rmid_busy got %b expected 0", if_a.busy); end
    compared++; if (if_a.rsp_valid !== 4'b0) begin mismatched++; $display("FAIL rmid_rsp got %b expected 0000", if_a.rsp_valid); end
    compared++; if (if_a.req_ready !== 4'b0) begin mismatched++; $display("FAIL rmid_ready got %b expected 0000", if_a.req_ready); end
    compared++; if (if_a.dbg_ptr !== 2'd0) begin mismatched++; $display("FAIL rmid_ptr got %0d expected 0", if_a.dbg_ptr); end
    @(posedge clk); #1;
    compared++; if (if_a.req_ready !== 4'b0) begin mismatched++; $display("FAIL rmid_ready_held got %b expected 0000", if_a.req_ready); end
    if_a.req_valid = '0;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      compared++; if (if_a.rsp_valid !== 4'b0 || if_a.busy !== 1'b0) begin mismatched++; $display("FAIL rmid_quiet c=%0d got %b/%b expected 0000/0", c, if_a.rsp_valid, if_a.busy); end
    end
  endtask

  task automatic test_latency_one();
    logic [3:0]  mr_pat;
    logic        m_v;
    logic        can;
    logic [1:0]  exp_r;
    logic [10:0] a;
    int          k;
    mr_pat = 4'b1101;
    m_v    = 1'b0;
    for (int c = 0; c < 16; c++) begin
      k = c % 2;
      a = 11'($urandom_range(0, 2047));
      if_b.mem_ready = mr_pat[c % 4];
      if_b.req_addr  = '0;
      if_b.req_addr[k*11 +: 11] = a;
      if_b.req_valid = 2'b01 << k;
      #1;
      can   = !m_v || if_b.mem_ready;
      exp_r = can ? (2'b01 << k) : 2'b00;
      compared++; if (if_b.req_ready !== exp_r) begin mismatched++; $display("FAIL lat1_grant c=%0d got %b expected %b", c, if_b.req_ready, exp_r); end
      if (can) begin
        exp_b_q.push_back({exp_r, mem_fn(a)});
        m_v = 1'b1;
      end
      @(posedge clk); #1;
    end
    if_b.req_valid = '0;
    if_b.mem_ready = 1'b1;
    for (int w = 0; w < 20 && if_b.busy; w++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    compared++; if (exp_b_q.size() != 0) begin mismatched++; $display("FAIL lat1_outstanding got %0d expected 0", exp_b_q.size()); end
    compared++; if (pulses_b != hs_b || hs_b == 0) begin mismatched++; $display("FAIL lat1_count got pulses=%0d expected handshakes=%0d", pulses_b, hs_b); end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_ptr_wrap();
    test_reset_mid();
    test_latency_one();
    @(posedge clk); #1;
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL final_outstanding_a got %0d expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
